bus_dma_master: RTL and testbench

Bus initiator that copies a block of 32-bit words from one slave address range to another over the shared two-master bus. It connects to one master port of the bus interconnect (m0 or m1 side). It requests the bus, holds request for the whole transfer, and issues alternating read and write cycles. It raises `done` when the last word has been written.

---
 rtl/bus_dma_master.sv | 124 ++++++++++++
 tb/tb_bus_dma_master.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_dma_master.sv
// Block-copy bus initiator: reads a word from the source range and then writes it to the
// destination range, word by word, while holding one bus tenure for the whole block.
//
// state | meaning
// IDLE  | waiting for start
// REQ   | requesting the bus, read address presented
// RD    | read address cycle
// LATCH | read data captured from the bus
// WR    | write cycle, word counter advances on grant
// DONE  | one-cycle completion pulse
module bus_dma_master (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [15:0] src_addr,
    input  logic [15:0] dst_addr,
    input  logic [7:0]  length,
    output logic        busy,
    output logic        done,
    output logic        m_req,
    output logic        m_wr,
    output logic [15:0] m_addr,
    output logic [31:0] m_dout,
    input  logic        m_grant,
    input  logic [31:0] m_din
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_RD,
        S_LATCH,
        S_WR,
        S_DONE
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [15:0] src_r;
    logic [15:0] dst_r;
    logic [7:0]  len_r;
    logic [7:0]  cnt;
    logic [7:0]  cnt_inc;
    logic [31:0] data_r;

    assign cnt_inc = cnt + 8'd1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= S_IDLE;
            src_r  <= 16'd0;
            dst_r  <= 16'd0;
            len_r  <= 8'd0;
            cnt    <= 8'd0;
            data_r <= 32'd0;
        end else begin
            state <= state_nxt;
            if (state == S_IDLE && start) begin
                src_r <= src_addr;
                dst_r <= dst_addr;
                len_r <= length;
                cnt   <= 8'd0;
            end
            if (state == S_LATCH) begin
                data_r <= m_din;
            end
            if (state == S_WR && m_grant) begin
                cnt <= cnt_inc;
            end
        end
    end

    // Losing the grant anywhere in a word sends it back to REQ; the word restarts from RD.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = (length == 8'd0) ? S_DONE : S_REQ;
                end
            end
            S_REQ:   state_nxt = m_grant ? S_RD : S_REQ;
            S_RD:    state_nxt = m_grant ? S_LATCH : S_REQ;
            S_LATCH: state_nxt = m_grant ? S_WR : S_REQ;
            S_WR: begin
                if (!m_grant) begin
                    state_nxt = S_REQ;
                end else if (cnt_inc == len_r) begin
                    state_nxt = S_DONE;
                end else begin
                    state_nxt = S_RD;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        m_req  = 1'b0;
        m_wr   = 1'b0;
        m_addr = 16'd0;
        m_dout = 32'd0;
        case (state)
            S_REQ, S_RD, S_LATCH: begin
                m_req  = 1'b1;
                m_addr = src_r + {8'd0, cnt};
            end
            S_WR: begin
                m_req  = 1'b1;
                m_wr   = 1'b1;
                m_addr = dst_r + {8'd0, cnt};
                m_dout = data_r;
            end
            default: begin
                m_req = 1'b0;
            end
        endcase
    end

    assign busy = (state != S_IDLE);
    assign done = (state == S_DONE);

endmodule

// File: tb/tb_bus_dma_master.sv
// Randomized bench for bus_dma_master: slave memory, grant generator and a block-copy
// reference model that predicts the ordered list of bus writes.
module tb_bus_dma_master;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [15:0] src_addr;
    logic [15:0] dst_addr;
    logic [7:0]  length;
    logic        busy;
    logic        done;
    logic        m_req;
    logic        m_wr;
    logic [15:0] m_addr;
    logic [31:0] m_dout;
    logic        m_grant;
    logic [31:0] m_din;

    always #5 clk = ~clk;

    bus_dma_master dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .src_addr (src_addr),
        .dst_addr (dst_addr),
        .length   (length),
        .busy     (busy),
        .done     (done),
        .m_req    (m_req),
        .m_wr     (m_wr),
        .m_addr   (m_addr),
        .m_dout   (m_dout),
        .m_grant  (m_grant),
        .m_din    (m_din)
    );

    typedef struct packed {
        logic [15:0] a;
        logic [31:0] d;
    } wr_t;

    logic [31:0] mem   [0:65535];
    logic [31:0] model [0:65535];
    wr_t         wr_q[$];
    wr_t         exp_q[$];

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          done_cnt = 0;
    int          done_cyc = 0;
    int          g_cyc = 0;
    int          req_gap = 0;
    int          viol = 0;
    int          req_seen = 0;
    bit          g_seen = 1'b0;
    int          grant_mode = 0;
    bit          arm_drop = 1'b0;
    int          drop_left = 0;
    logic        req_prev = 1'b0;
    logic [15:0] prev_addr = 16'd0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Grant generator, slave with one-cycle registered read data, and bus monitor.
    always @(negedge clk) begin
        cyc++;
        if (!reset_n) begin
            m_grant   = 1'b0;
            req_prev  = 1'b0;
            drop_left = 0;
        end else begin
            if (drop_left > 0) begin
                m_grant = 1'b0;
                drop_left--;
            end else if (arm_drop && m_wr && wr_q.size() == 1) begin
                m_grant   = 1'b0;
                arm_drop  = 1'b0;
                drop_left = 1;
            end else if (grant_mode == 1) begin
                m_grant = m_req && req_prev && ($urandom_range(0, 3) != 0);
            end else begin
                m_grant = m_req && req_prev;
            end
            req_prev = m_req;
        end
        m_din     = mem[prev_addr];
        prev_addr = m_addr;
        if (m_req && m_grant && m_wr) begin
            wr_q.push_back('{a: m_addr, d: m_dout});
            mem[m_addr] = m_dout;
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (m_req) req_seen++;
        if (m_req && m_grant && !g_seen) begin
            g_seen = 1'b1;
            g_cyc  = cyc;
        end
        if (busy && !done && !m_req) req_gap++;
        if (!m_wr && m_dout != 32'd0) viol++;
        if (!m_req && (m_wr || m_addr != 16'd0)) viol++;
        if (done && !busy) viol++;
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_mon();
        wr_q.delete();
        done_cnt = 0;
        g_seen   = 1'b0;
        req_gap  = 0;
        viol     = 0;
        req_seen = 0;
    endtask

    task automatic start_cmd(input logic [15:0] s, input logic [15:0] d, input logic [7:0] n);
        start    = 1'b1;
        src_addr = s;
        dst_addr = d;
        length   = n;
        step();
        start = 1'b0;
    endtask

    // Reference: ascending word copy applied to a snapshot of memory.
    task automatic begin_copy(input logic [15:0] s, input logic [15:0] d, input int n, input int mode);
        grant_mode = mode;
        model = mem;
        exp_q.delete();
        for (int i = 0; i < n; i++) begin
            logic [15:0] sa;
            logic [15:0] da;
            sa = 16'(s + i);
            da = 16'(d + i);
            model[da] = model[sa];
            exp_q.push_back('{a: da, d: model[sa]});
        end
        clear_mon();
        start_cmd(s, d, 8'(n));
    endtask

    task automatic finish_copy(input string tag, input int bound);
        int n;
        for (int i = 0; i < bound && done_cnt == 0; i++) step();
        chk({tag, "_done_seen"}, 32'(done_cnt != 0), 32'd1);
        repeat (3) step();
        chk({tag, "_nwr"}, 32'(wr_q.size()), 32'(exp_q.size()));
        n = (wr_q.size() < exp_q.size()) ? wr_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s_wa%0d", tag, i), 32'(wr_q[i].a), 32'(exp_q[i].a));
            chk($sformatf("%s_wd%0d", tag, i), wr_q[i].d, exp_q[i].d);
        end
        chk({tag, "_done_once"}, 32'(done_cnt), 32'd1);
        chk({tag, "_req_gap"}, 32'(req_gap), 32'd0);
        chk({tag, "_idle_outs"}, 32'(viol), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = $urandom;
        reset_n  = 1'b0;
        start    = 1'b1;
        src_addr = 16'h1234;
        dst_addr = 16'h4321;
        length   = 8'd5;
        m_grant  = 1'b0;
        m_din    = 32'd0;
        repeat (3) step();
        chk("rst_req", 32'(m_req), 32'd0);
        chk("rst_wr", 32'(m_wr), 32'd0);
        chk("rst_addr", 32'(m_addr), 32'd0);
        chk("rst_dout", m_dout, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        start   = 1'b0;
        reset_n = 1'b1;
        repeat (4) step();
        chk("post_rst_busy", 32'(busy), 32'd0);
        chk("post_rst_req", 32'(m_req), 32'd0);

        begin_copy(16'h0010, 16'h0100, 4, 0);
        chk("c4_req_after_start", 32'(m_req), 32'd1);
        chk("c4_busy_after_start", 32'(busy), 32'd1);
        finish_copy("c4", 200);
        chk("c4_latency", 32'(done_cyc - g_cyc), 32'd13);

        clear_mon();
        start_cmd(16'h0040, 16'h0050, 8'd0);
        chk("z_done", 32'(done), 32'd1);
        chk("z_busy", 32'(busy), 32'd1);
        chk("z_req", 32'(m_req), 32'd0);
        step();
        chk("z_done_drop", 32'(done), 32'd0);
        chk("z_busy_drop", 32'(busy), 32'd0);
        chk("z_req_seen", 32'(req_seen), 32'd0);
        chk("z_done_once", 32'(done_cnt), 32'd1);

        begin_copy(16'hFFFE, 16'h7FFF, 3, 0);
        finish_copy("wrap", 200);

        arm_drop = 1'b1;
        begin_copy(16'h0200, 16'h0A00, 3, 0);
        finish_copy("gloss", 200);
        chk("gloss_fired", 32'(arm_drop), 32'd0);
        arm_drop = 1'b0;

        begin_copy(16'h0300, 16'h0B00, 6, 0);
        repeat (4) step();
        start_cmd(16'h0900, 16'h0C00, 8'd2);
        finish_copy("busyprot", 300);

        begin_copy(16'h0400, 16'h0D00, 5, 0);
        for (int i = 0; i < 100 && wr_q.size() == 0; i++) step();
        step();
        chk("mr_in_latch_req", 32'(m_req), 32'd1);
        chk("mr_in_latch_wr", 32'(m_wr), 32'd0);
        reset_n = 1'b0;
        #1;
        chk("mr_req_async", 32'(m_req), 32'd0);
        chk("mr_busy_async", 32'(busy), 32'd0);
        repeat (3) step();
        reset_n = 1'b1;
        repeat (3) step();
        chk("mr_no_done", 32'(done_cnt), 32'd0);
        begin_copy(16'h0400, 16'h0D00, 5, 0);
        finish_copy("mr_rerun", 300);

        for (int r = 0; r < 6; r++) begin
            logic [15:0] s;
            logic [15:0] d;
            s = 16'($urandom);
            d = (r == 2) ? 16'(s + 1) : 16'($urandom);
            begin_copy(s, d, int'($urandom_range(1, 24)), 1);
            finish_copy($sformatf("rnd%0d", r), 4000);
        end

        begin_copy(16'h5000, 16'h6000, 255, 0);
        finish_copy("len255", 2000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
